// File: rtl/bin_gray_pkg.sv
// Shared definitions for the streaming binary-to-Gray encoder.
// Optional build macro: BIN_GRAY_STEP_CHECK_EN (see bin_gray_enc.sv).
package bin_gray_pkg;

    // Number of register stages between input accept and output.
    localparam int PIPE_DEPTH = 2;

    // Widest word the helper functions handle; callers zero-extend to this
    // width and truncate the result back to their own word width.
    localparam int MAX_W = 64;

    // g = b ^ (b >> 1). Zero-extension keeps the MSB equal to b's MSB.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Number of set bits in v.
    function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/bin_gray_enc_if.sv
// Valid/ready stream bundle for the encoder: binary words in, Gray words out.
// slave = the encoder, master = the producer/consumer driving it.
interface bin_gray_enc_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/bin_gray_stage.sv
// One valid/ready register slice carrying a data word and a last flag.
// Loads whenever it is empty or its content leaves in the same cycle, so a
// chain of slices sustains one word per cycle.
module bin_gray_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data_i,
    input  logic         in_last_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_last_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);
    logic [W-1:0] data_q, data_d;
    logic         last_q, last_d;
    logic         valid_q, valid_d;
    logic         go;

    // The slot frees up when empty or when the downstream takes the word.
    assign go         = !valid_q || out_ready_i;
    assign in_ready_o = go;

    // Next state: hold unless the slot advances; data only moves on a load.
    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (go) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
                last_d = in_last_i;
            end
        end
    end

    // Slice registers; reset discards whatever is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign out_valid_o = valid_q;
endmodule

// File: rtl/bin_gray_enc.sv
// Streaming binary-to-Gray encoder: two register slices with the Gray
// conversion between them, an emitted-word counter, and an optional check
// that consecutive output words within a burst differ in exactly one bit.
// Optional build macro: BIN_GRAY_STEP_CHECK_EN enables the adjacency check;
// without it step_err is constant 0.
module bin_gray_enc
    import bin_gray_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    bin_gray_enc_if.slave    bus,
    output logic [CNT_W-1:0] out_cnt,
    output logic             step_err
);
    logic [WIDTH-1:0] s1_data;
    logic             s1_last;
    logic             s1_valid;
    logic             s2_ready;
    logic [WIDTH-1:0] s1_gray;
    logic             out_hs;

    // S1 holds the raw binary word. Its ready depends combinationally on
    // out_ready through S2, which is what gives full throughput.
    bin_gray_stage #(.W(WIDTH)) u_s1 (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (bus.in_data),
        .in_last_i   (bus.in_last),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .out_data_o  (s1_data),
        .out_last_o  (s1_last),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_ready)
    );

    assign s1_gray = WIDTH'(bin2gray(MAX_W'(s1_data)));

    // S2 holds the encoded word and drives the output side directly.
    bin_gray_stage #(.W(WIDTH)) u_s2 (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (s1_gray),
        .in_last_i   (s1_last),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_ready),
        .out_data_o  (bus.out_data),
        .out_last_o  (bus.out_last),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready)
    );

    assign out_hs = bus.out_valid && bus.out_ready;

    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    // Emitted-word counter; wraps naturally at 2^CNT_W.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (out_hs) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt_q <= '0;
        end else begin
            out_cnt_q <= out_cnt_d;
        end
    end

    assign out_cnt = out_cnt_q;

`ifdef BIN_GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_g_q, prev_g_d;
    logic             prev_v_q, prev_v_d;
    logic             step_err_q, step_err_d;

    // Compare each emitted word with the previous one of the same burst;
    // a last word ends the burst so the next word is not compared to it.
    always_comb begin
        prev_g_d   = prev_g_q;
        prev_v_d   = prev_v_q;
        step_err_d = step_err_q;
        if (out_hs) begin
            if (prev_v_q && (popcount(MAX_W'(bus.out_data ^ prev_g_q)) != 1)) begin
                step_err_d = 1'b1;
            end
            prev_g_d = bus.out_data;
            prev_v_d = !bus.out_last;
        end
    end

    // Checker registers; step_err is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_g_q   <= '0;
            prev_v_q   <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            prev_g_q   <= prev_g_d;
            prev_v_q   <= prev_v_d;
            step_err_q <= step_err_d;
        end
    end

    assign step_err = step_err_q;
`else
    assign step_err = 1'b0;
`endif

endmodule
